// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// The producer/consumer side uses master; the adder itself uses slave.
interface pipe_addsub_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     termA;
    logic [N-1:0]     termB;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     sum;
    logic             carry;
    logic             overflow;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, termA, termB, sub, in_tag, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, out_tag
    );

    modport slave (
        input  in_valid, termA, termB, sub, in_tag, out_ready,
        output in_ready, out_valid, sum, carry, overflow, out_tag
    );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the N-bit carry chain is cut into STAGES
// registered slices of W = N/STAGES bits, with a global valid/ready stall.
// Each stage register holds the operation *entering* that stage: the
// operand slices still to be added, the carry into its slice, the sum
// slices already produced, the tag and a valid bit. The slice adder sits
// after the register, so the last stage's adder drives the outputs.
module pipe_addsub #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    pipe_addsub_if.slave bus
);
    localparam int unsigned W    = N / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_addsub: STAGES must lie in 1..N and divide N");
    end

    // Every stage moves together; a held result freezes the whole pipe.
    logic adv;
    assign adv         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed on entry to stage k: slices k..STAGES-1.
        localparam int unsigned RW = N - k * W;

        logic [RW-1:0]    a_r;
        logic [RW-1:0]    b_r;
        logic             c_r;
        logic             v_r;
        logic [N-1:0]     s_r;
        logic [TAG_W-1:0] t_r;
        logic [W:0]       slice;
        logic [N-1:0]     s_nxt;

        // Slice k of A + B' + carry-in; slice k of s_r is always zero, so OR inserts it.
        always_comb begin
            slice = {1'b0, a_r[W-1:0]} + {1'b0, b_r[W-1:0]} + {{W{1'b0}}, c_r};
            s_nxt = s_r | (N'(slice[W-1:0]) << (k * W));
        end

        if (k == 0) begin : g_load
            // Capture a new operation; subtraction inverts B and seeds carry-in with 1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                    s_r <= '0;
                    t_r <= '0;
                end else if (adv) begin
                    v_r <= bus.in_valid;
                    a_r <= bus.termA;
                    b_r <= bus.sub ? ~bus.termB : bus.termB;
                    c_r <= bus.sub;
                    s_r <= '0;
                    t_r <= bus.in_tag;
                end
            end
        end else begin : g_shift
            // Take the previous stage's carry-out, partial sum and remaining operand slices.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_r <= 1'b0;
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                    s_r <= '0;
                    t_r <= '0;
                end else if (adv) begin
                    v_r <= g_stage[k-1].v_r;
                    a_r <= g_stage[k-1].a_r[N - (k - 1) * W - 1 : W];
                    b_r <= g_stage[k-1].b_r[N - (k - 1) * W - 1 : W];
                    c_r <= g_stage[k-1].slice[W];
                    s_r <= g_stage[k-1].s_nxt;
                    t_r <= g_stage[k-1].t_r;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[LAST].v_r;
    assign bus.sum       = g_stage[LAST].s_nxt;
    assign bus.carry     = g_stage[LAST].slice[W];
    assign bus.out_tag   = g_stage[LAST].t_r;
    assign bus.overflow  = (g_stage[LAST].a_r[W-1] == g_stage[LAST].b_r[W-1]) &&
                           (g_stage[LAST].slice[W-1] != g_stage[LAST].a_r[W-1]);
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed cases on an 8-bit/2-stage instance, then
// randomized traffic with random backpressure on that instance and on
// 32-bit instances with 1, 4 and 32 stages, checked against an
// integer-arithmetic reference model.
module tb_pipe_addsub;
    localparam int NOPS = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Producer/consumer drive, one lane per DUT: 0 = N8/S2, 1 = S1, 2 = S4, 3 = S32.
    logic [3:0]  iv   = '0;
    logic [3:0]  sb   = '0;
    logic [3:0]  ordy = '1;
    logic [31:0] ta  [4];
    logic [31:0] tbv [4];
    logic [3:0]  tg  [4];

    // Observed outputs per lane.
    logic [3:0]  rdy, ov, oc, oo;
    logic [31:0] os [4];
    logic [3:0]  ot [4];

    int checks = 0;
    int errors = 0;

    logic [37:0] q [4][$];

    pipe_addsub_if #(.N(8),  .TAG_W(4)) b8  ();
    pipe_addsub_if #(.N(32), .TAG_W(4)) b1  ();
    pipe_addsub_if #(.N(32), .TAG_W(4)) b4  ();
    pipe_addsub_if #(.N(32), .TAG_W(4)) b32 ();

    pipe_addsub #(.N(8),  .STAGES(2),  .TAG_W(4)) u8  (.clk(clk), .rst(rst), .bus(b8));
    pipe_addsub #(.N(32), .STAGES(1),  .TAG_W(4)) u1  (.clk(clk), .rst(rst), .bus(b1));
    pipe_addsub #(.N(32), .STAGES(4),  .TAG_W(4)) u4  (.clk(clk), .rst(rst), .bus(b4));
    pipe_addsub #(.N(32), .STAGES(32), .TAG_W(4)) u32 (.clk(clk), .rst(rst), .bus(b32));

    assign b8.in_valid = iv[0]; assign b8.termA = ta[0][7:0]; assign b8.termB = tbv[0][7:0];
    assign b8.sub = sb[0]; assign b8.in_tag = tg[0]; assign b8.out_ready = ordy[0];
    assign rdy[0] = b8.in_ready; assign ov[0] = b8.out_valid; assign os[0] = {24'd0, b8.sum};
    assign oc[0] = b8.carry; assign oo[0] = b8.overflow; assign ot[0] = b8.out_tag;

    assign b1.in_valid = iv[1]; assign b1.termA = ta[1]; assign b1.termB = tbv[1];
    assign b1.sub = sb[1]; assign b1.in_tag = tg[1]; assign b1.out_ready = ordy[1];
    assign rdy[1] = b1.in_ready; assign ov[1] = b1.out_valid; assign os[1] = b1.sum;
    assign oc[1] = b1.carry; assign oo[1] = b1.overflow; assign ot[1] = b1.out_tag;

    assign b4.in_valid = iv[2]; assign b4.termA = ta[2]; assign b4.termB = tbv[2];
    assign b4.sub = sb[2]; assign b4.in_tag = tg[2]; assign b4.out_ready = ordy[2];
    assign rdy[2] = b4.in_ready; assign ov[2] = b4.out_valid; assign os[2] = b4.sum;
    assign oc[2] = b4.carry; assign oo[2] = b4.overflow; assign ot[2] = b4.out_tag;

    assign b32.in_valid = iv[3]; assign b32.termA = ta[3]; assign b32.termB = tbv[3];
    assign b32.sub = sb[3]; assign b32.in_tag = tg[3]; assign b32.out_ready = ordy[3];
    assign rdy[3] = b32.in_ready; assign ov[3] = b32.out_valid; assign os[3] = b32.sum;
    assign oc[3] = b32.carry; assign oo[3] = b32.overflow; assign ot[3] = b32.out_tag;

    function automatic int width(int d);
        return (d == 0) ? 8 : 32;
    endfunction

    // Reference: plain integer arithmetic on n-bit unsigned and signed values.
    function automatic logic [37:0] model(int n, logic [31:0] a, logic [31:0] b,
                                          logic s, logic [3:0] tag);
        longint full = longint'(1) << n;
        longint half = full >> 1;
        longint ua   = longint'(a) & (full - 1);
        longint ub   = longint'(b) & (full - 1);
        longint sa   = (ua >= half) ? ua - full : ua;
        longint sbv  = (ub >= half) ? ub - full : ub;
        longint r    = s ? ua - ub : ua + ub;
        longint sr   = s ? sa - sbv : sa + sbv;
        logic [31:0] rs = 32'(r & (full - 1));
        logic        c  = s ? (ua >= ub) : (r >= full);
        logic        o  = (sr < -half) || (sr >= half);
        return {rs, c, o, tag};
    endfunction

    function automatic logic [37:0] obs(int d);
        return {os[d], oc[d], oo[d], ot[d]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation on lane 0; result must appear after exactly two edges.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] tag, input logic [7:0] es, input logic ec,
                       input logic eo, input string name);
        iv[0] = 1'b1; ta[0] = {24'd0, a}; tbv[0] = {24'd0, b}; sb[0] = s; tg[0] = tag;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, rdy[0], 1);
        tick();
        iv[0] = 1'b0;
        @(negedge clk);
        chk({name, "_early_valid"}, ov[0], 0);
        tick();
        @(negedge clk);
        chk({name, "_valid"}, ov[0], 1);
        chk({name, "_sum"}, os[0], {24'd0, es});
        chk({name, "_carry"}, oc[0], ec);
        chk({name, "_overflow"}, oo[0], eo);
        chk({name, "_tag"}, ot[0], tag);
        tick();
    endtask

    initial begin
        logic [7:0]  sA [8];
        logic [7:0]  sB [8];
        logic        sS [8];
        logic [37:0] snap;
        logic [37:0] expv;
        int          p, r;
        int          nsent [4];
        int          nrecv [4];
        logic [3:0]  acc;
        logic        done;

        for (int d = 0; d < 4; d++) begin
            ta[d] = '0; tbv[d] = '0; tg[d] = '0;
        end

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", ov, 4'h0);
        chk("rst_in_ready", rdy, 4'hf);
        chk("rst_sum", os[0], 0);
        chk("rst_carry", oc[0], 0);
        chk("rst_overflow", oo[0], 0);
        chk("rst_tag", ot[0], 0);
        tick();

        // Directed arithmetic cases
        op8(8'd200, 8'd100, 1'b0, 4'd3, 8'd44,  1'b1, 1'b0, "add_200_100");
        op8(8'd100, 8'd50,  1'b0, 4'd5, 8'd150, 1'b0, 1'b1, "add_100_50");
        op8(8'd5,   8'd10,  1'b1, 4'd6, 8'd251, 1'b0, 1'b0, "sub_5_10");
        op8(8'd128, 8'd1,   1'b1, 4'd9, 8'd127, 1'b1, 1'b1, "sub_128_1");
        op8(8'd0,   8'd0,   1'b1, 4'd15, 8'd0,  1'b1, 1'b0, "sub_0_0");

        // Stream of 8 with a 3-cycle consumer stall in cycles 3..5
        for (int i = 0; i < 8; i++) begin
            sA[i] = 8'($urandom); sB[i] = 8'($urandom); sS[i] = 1'($urandom_range(1));
        end
        p = 0; r = 0; snap = '0;
        for (int cyc = 0; cyc < 40 && r < 8; cyc++) begin
            iv[0] = (p < 8);
            if (p < 8) begin
                ta[0] = {24'd0, sA[p]}; tbv[0] = {24'd0, sB[p]}; sb[0] = sS[p]; tg[0] = 4'(p);
            end
            ordy[0] = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            chk($sformatf("stream_in_ready_c%0d", cyc), rdy[0], (cyc >= 3 && cyc <= 5) ? 0 : 1);
            if (cyc >= 3 && cyc <= 5) chk($sformatf("stall_valid_c%0d", cyc), ov[0], 1);
            if (cyc >= 4 && cyc <= 5) chk($sformatf("stall_hold_c%0d", cyc), obs(0), snap);
            if (cyc == 3) snap = obs(0);
            if (iv[0] && rdy[0]) begin
                q[0].push_back(model(8, ta[0], tbv[0], sb[0], tg[0]));
                p++;
            end
            if (ov[0] && ordy[0]) begin
                checks++;
                assert (q[0].size() != 0) else begin
                    errors++;
                    $error("FAIL stream_spurious: observed extra result tag %0d, expected none", ot[0]);
                end
                if (q[0].size() != 0) begin
                    expv = q[0].pop_front();
                    chk($sformatf("stream_r%0d", r), obs(0), expv);
                    r++;
                end
            end
            tick();
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        chk("stream_count", r, 8);
        chk("stream_leftover", q[0].size(), 0);

        // Reset with two operations in flight
        ordy[0] = 1'b0;
        iv[0] = 1'b1; ta[0] = 32'd10; tbv[0] = 32'd20; sb[0] = 1'b0; tg[0] = 4'd1;
        tick();
        ta[0] = 32'd30; tg[0] = 4'd2;
        tick();
        iv[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pre_valid", ov[0], 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", ov[0], 0);
        chk("midrst_fields", obs(0), 0);
        chk("midrst_in_ready", rdy[0], 1);
        ordy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("midrst_no_emit_%0d", i), ov[0], 0);
        end
        tick();

        // Randomized traffic on all four instances
        iv = '0;
        for (int d = 0; d < 4; d++) begin
            nsent[d] = 0; nrecv[d] = 0;
        end
        for (int cyc = 0; cyc < 60000; cyc++) begin
            done = 1'b1;
            for (int d = 0; d < 4; d++) if (nrecv[d] != NOPS) done = 1'b0;
            if (done) break;
            for (int d = 0; d < 4; d++) begin
                if (!iv[d] && nsent[d] < NOPS && $urandom_range(3) != 0) begin
                    iv[d] = 1'b1; ta[d] = $urandom; tbv[d] = $urandom;
                    sb[d] = 1'($urandom_range(1)); tg[d] = 4'(nsent[d]);
                end
                ordy[d] = ($urandom_range(3) != 0);
            end
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                acc[d] = iv[d] && rdy[d];
                if (acc[d]) begin
                    q[d].push_back(model(width(d), ta[d], tbv[d], sb[d], tg[d]));
                    nsent[d]++;
                end
                if (ov[d] && ordy[d]) begin
                    checks++;
                    assert (q[d].size() != 0) else begin
                        errors++;
                        $error("FAIL rand_spurious_dut%0d: observed extra result tag %0d, expected none", d, ot[d]);
                    end
                    if (q[d].size() != 0) begin
                        expv = q[d].pop_front();
                        chk($sformatf("rand_dut%0d_op%0d", d, nrecv[d]), obs(d), expv);
                        nrecv[d]++;
                    end
                end
            end
            tick();
            for (int d = 0; d < 4; d++) if (acc[d]) iv[d] = 1'b0;
        end
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rand_dut%0d_received", d), nrecv[d], NOPS);
            chk($sformatf("rand_dut%0d_leftover", d), q[d].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
